// File: rtl/fifobram_fifo_if.sv
// rtl/fifobram_fifo_if.sv - producer/consumer bundle for the BRAM-backed FIFO
interface fifobram_fifo_if #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 5
);
  logic                  flush;
  logic                  we;
  logic [WIDTH-1:0]      wdata;
  logic                  re;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  almostfull;
  logic                  empty;
  logic [LOG2_DEPTH-1:0] count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, we, wdata, re,
    input  rdata, rvalid, almostfull, empty, count, overflow, underflow
  );

  modport slave (
    input  flush, we, wdata, re,
    output rdata, rvalid, almostfull, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifobram_fifo.sv
// rtl/fifobram_fifo.sv - BRAM-backed synchronous FIFO with registered status and sticky error flags
module fifobram_fifo #(
  parameter int WIDTH            = 32,
  parameter int LOG2_DEPTH       = 5,
  parameter int ALMOSTFULL_LEVEL = 2**LOG2_DEPTH - 8
) (
  input  logic           clk,
  input  logic           reset_n,
  fifobram_fifo_if.slave bus
);
  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] CAP    = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] AF_LVL = LOG2_DEPTH'(ALMOSTFULL_LEVEL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2_DEPTH-1:0] rptr_q, rptr_d;
  logic [LOG2_DEPTH-1:0] count_q, count_d;
  logic                  empty_q, almostfull_q, rvalid_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  overflow_q, underflow_q;
  logic                  pop, push, do_pop, do_push;

  always_comb begin
    // Pop qualifies on the registered empty, so a same-cycle write never falls through.
    pop     = bus.re && !empty_q;
    push    = bus.we && ((count_q != CAP) || pop);
    do_pop  = pop && !bus.flush;
    do_push = push && !bus.flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + LOG2_DEPTH'(push) - LOG2_DEPTH'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      almostfull_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      empty_q      <= (count_d == '0);
      almostfull_q <= (count_d >= AF_LVL);
      rvalid_q     <= do_pop;
      if (do_pop) rdata_q <= mem[rptr_q];
      overflow_q   <= overflow_q  | (bus.we && !push);
      underflow_q  <= underflow_q | (bus.re && empty_q);
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.almostfull = almostfull_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_fifobram_fifo.sv
// tb/tb_fifobram_fifo.sv - directed bench with queue model and read-data scoreboard for fifobram_fifo
module tb_fifobram_fifo;
  localparam int W   = 32;
  localparam int L   = 5;
  localparam int CAP = 31;
  localparam int AF  = 24;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifobram_fifo_if #(.WIDTH(W), .LOG2_DEPTH(L)) bus ();

  fifobram_fifo #(.WIDTH(W), .LOG2_DEPTH(L), .ALMOSTFULL_LEVEL(AF)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] store [$];
  logic [W-1:0] sb [$];
  int   mcount;
  bit   mrv, movf, munf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    store.delete();
    sb.delete();
    mcount = 0;
    mrv    = 0;
    movf   = 0;
    munf   = 0;
  endtask

  task automatic check_all();
    logic [W-1:0] e;
    chk("count", 64'(bus.count), 64'(mcount));
    chk("empty", 64'(bus.empty), 64'(mcount == 0));
    chk("almostfull", 64'(bus.almostfull), 64'(mcount >= AF));
    chk("overflow", 64'(bus.overflow), 64'(movf));
    chk("underflow", 64'(bus.underflow), 64'(munf));
    chk("rvalid", 64'(bus.rvalid), 64'(mrv));
    if (bus.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rdata_unexpected", 64'(bus.rdata), 64'hdead_beef_dead_beef);
      end else begin
        e = sb.pop_front();
        chk("rdata", 64'(bus.rdata), 64'(e));
      end
    end
  endtask

  task automatic cycle(input bit we, input logic [W-1:0] wd, input bit re, input bit fl);
    bit pop, push;
    bus.we    = we;
    bus.wdata = wd;
    bus.re    = re;
    bus.flush = fl;
    pop  = re && (mcount != 0);
    push = we && ((mcount != CAP) || pop);
    if (we && !push) movf = 1;
    if (re && mcount == 0) munf = 1;
    @(posedge clk);
    if (fl) begin
      store.delete();
      mcount = 0;
      mrv    = 0;
    end else begin
      mrv = pop;
      if (pop) sb.push_back(store.pop_front());
      if (push) store.push_back(wd);
      mcount = store.size();
    end
    #1;
    check_all();
    bus.we = 0; bus.re = 0; bus.flush = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.we = 0; bus.re = 0; bus.flush = 0; bus.wdata = '0;
    model_clear();
    reset_n = 1'b0;
    #12;
    check_all();
    chk("reset_rdata", 64'(bus.rdata), 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic three-word write then read
    cycle(1, 32'h11, 0, 0);
    cycle(1, 32'h22, 0, 0);
    cycle(1, 32'h33, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("t1_last_rdata", 64'(bus.rdata), 64'h33);

    // Fill to capacity, overflow, pop first word
    for (int i = 0; i < CAP; i++) begin
      cycle(1, 32'h100 + 32'(i), 0, 0);
      if (i == AF - 2) chk("af_below", 64'(bus.almostfull), 64'h0);
      if (i == AF - 1) chk("af_at24", 64'(bus.almostfull), 64'h1);
    end
    cycle(1, 32'hbad, 0, 0);
    chk("ovf_count", 64'(bus.count), 64'(CAP));
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("first_word", 64'(bus.rdata), 64'h100);

    // Full FIFO accepts a write together with a pop
    cycle(0, '0, 0, 1);
    for (int i = 0; i < CAP; i++) cycle(1, 32'h200 + 32'(i), 0, 0);
    cycle(1, 32'h2ff, 1, 0);
    chk("full_wr_rd_count", 64'(bus.count), 64'(CAP));
    for (int i = 0; i < CAP; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("last_drained", 64'(bus.rdata), 64'h2ff);

    // Simultaneous we/re on empty is an underflow, no fall-through
    cycle(1, 32'h77, 1, 0);
    chk("unf_set", 64'(bus.underflow), 64'h1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Streaming across several pointer wraps with clean flags
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0);
    for (int i = 0; i < 100; i++) cycle(1, $urandom, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("stream_flags", 64'({bus.overflow, bus.underflow}), 64'h0);

    // Flush with a concurrent read
    for (int i = 0; i < 10; i++) cycle(1, 32'h300 + 32'(i), 0, 0);
    cycle(0, '0, 1, 1);
    chk("flush_empty", 64'(bus.empty), 64'h1);
    cycle(0, '0, 0, 0);

    // Asynchronous reset mid-stream, off a clock edge
    for (int i = 0; i < 6; i++) cycle(1, 32'h400 + 32'(i), 0, 0);
    cycle(1, 32'h499, 1, 0);
    cycle(1, 32'h4aa, 1, 0);
    bus.we = 1; bus.re = 1; bus.wdata = 32'h4bb;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all();
    chk("async_rdata", 64'(bus.rdata), 64'h0);
    bus.we = 0; bus.re = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
